mlp_layer_engine: RTL and testbench
===================================

# mlp_layer_engine

Parametrised, time-multiplexed fully-connected layer for the MLP inference datapath. One engine computes N_NEU neurons in parallel over N_IN inputs using signed fixed-point MAC lanes. Each output gets bias add, rounding shift, saturation and optional ReLU, plus a registered argmax. It replaces the fixed 10-lane, 8-bit, hard-indexed hidden/output datapath. Hidden and output layers are separate instances with different parameters, sequenced by the top-level controller through a start/done handshake.

## Interface
Parameters:
- DATA_W, 8, width of signed data, weights and biases
- FRAC, 7, fractional bits of weights (Q1.7 at default)
- N_IN, 62, inputs per neuron
- N_NEU, 10, neurons (MAC lanes)
- ACC_W, 24, signed accumulator width
- RELU, 1, 1 = clamp negative outputs to 0; 0 = linear output

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- busy  out  1  high from the cycle after start through ACT
- done  out  1  one-cycle pulse when out_vec/argmax update
- in_addr  out  clog2(N_IN)  input-vector read address
- in_data  in  DATA_W  signed input; sync memory, 1-cycle read latency
- w_addr  out  clog2(N_IN)  weight-column address; same timing as in_addr
- w_data  in  N_NEU*DATA_W  one signed weight per lane; lane n at [n*DATA_W +: DATA_W]
- b_data  in  N_NEU*DATA_W  per-lane signed bias; must be stable while busy
- out_vec  out  N_NEU*DATA_W  registered layer outputs, same packing
- argmax  out  clog2(N_NEU)  index of the largest out_vec lane

## Operation
- FSM states: IDLE, MAC, DRAIN, ACT.
- IDLE -> MAC on start. At that same edge, each lane's acc is set to sign_ext(bias) << FRAC and k is set to 0.
- MAC: drives in_addr = w_addr = k. k increments each cycle. After k = N_IN-1 the FSM goes to DRAIN.
- Each lane accumulates acc += in_data * w_data[lane], signed 2*DATA_W product, sign-extended to ACC_W. The accumulate happens in the cycle after the corresponding address is issued, i.e. during MAC cycles 2..N_IN and in DRAIN.
- DRAIN: absorbs the last product. DRAIN -> ACT.
- ACT:
  - per lane y = acc >>> FRAC, arithmetic shift, truncating toward -inf
  - saturate y to [-2^(DATA_W-1), 2^(DATA_W-1)-1]
  - if RELU, negative y becomes 0
  - out_vec, argmax and done register at the end of ACT; ACT -> IDLE
- argmax selects the largest signed out_vec value. Ties go to the lowest index.
- Between runs, out_vec and argmax hold their last value.
- start while busy is ignored and not queued.
- Reset (any state, asynchronous): FSM -> IDLE; k, acc, out_vec, argmax = 0; busy = done = 0. Addresses are 0 while in IDLE.
- Elaboration check: ACC_W >= 2*DATA_W + clog2(N_IN+1) + 1, with error on violation. The accumulator then never wraps.

## Timing
- Cycle 0 = start sampled. MAC occupies cycles 1..N_IN, DRAIN is N_IN+1, ACT is N_IN+2.
- done is high in cycle N_IN+3 only. Latency start->done = N_IN+3; default parameters give 65.
- busy is high in cycles 1..N_IN+2.
- A new start is accepted in the done cycle (the FSM is already IDLE). Back-to-back throughput is one layer per N_IN+3 cycles.
- Address outputs are combinational from the state/k registers. No combinational path from any input to any output except through registers.

## Structure
- mlp_pkg: state enum, the saturate/ReLU function, and a clog2-based width helper.
- Sub-module mac_lane: one per neuron, generated N_NEU times.
  - Ports: clk, rst, init, en, bias, x, w, result.
  - Contains the acc register and the ACT post-processing.
- The top level holds the FSM, the k counter and the argmax reduction.

## Test plan
- N_IN=4, N_NEU=2, RELU=0. inputs {64,64,64,64}, weights lane0 all 64, lane1 all -64, bias 0 -> out_vec lane0 = 128 saturates to 127; lane1 = -128; argmax = 0; done exactly at cycle 7.
- Default params, all weights 0, biases {0..9}. Lane n output = n<<7>>>7 = n; argmax = 9. Repeat with biases all 5 -> argmax = 0 (tie rule).
- RELU=1, lane accumulating to -300<<7 -> output 0. Same case with RELU=0 -> output -128.
- Pulse start while busy at cycle 10 -> ignored. Exactly one done at cycle N_IN+3; busy never drops early.
- Assert rst low during MAC cycle 20 -> busy, done, out_vec and argmax go 0 immediately. A start after release runs a clean full-latency pass with correct results.
- Random back-to-back runs, start issued in each done cycle, 1000 vectors versus a reference model -> bit-exact out_vec/argmax and no lost starts.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types and helpers for the fully-connected layer engine.
package mlp_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, ACT} state_t;

  // Width for an index over n items; never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp to a signed dw-bit range, then optionally zero negatives.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] y,
                                                  input int dw, input bit relu);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (y > hi) return hi;
    if (y < lo) return relu ? '0 : lo;
    if (relu && y[63]) return '0;
    return y;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One neuron: bias-seeded accumulator plus shift/saturate/ReLU post-processing.
module mac_lane
  import mlp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC   = 7,
  parameter int ACC_W  = 24,
  parameter bit RELU   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  output logic        [DATA_W-1:0] result
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = (2*DATA_W)'(x) * (2*DATA_W)'(w);

  always_ff @(posedge clk or negedge rst)
    if (!rst)      acc <= '0;
    else if (init) acc <= ACC_W'(bias) <<< FRAC;
    else if (en)   acc <= acc + ACC_W'(prod);

  // Arithmetic shift floors toward -inf; saturation works on a wide copy.
  assign result = DATA_W'(sat_relu(64'(acc >>> FRAC), DATA_W, RELU));

endmodule

// File: rtl/mlp_layer_engine.sv
// Time-multiplexed FC layer: N_NEU MAC lanes stepped over N_IN inputs, then
// post-processed and reduced to a registered argmax.
module mlp_layer_engine
  import mlp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FRAC   = 7,
  parameter int N_IN   = 62,
  parameter int N_NEU  = 10,
  parameter int ACC_W  = 24,
  parameter bit RELU   = 1'b1,
  localparam int A_W   = cw(N_IN),
  localparam int M_W   = cw(N_NEU)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [A_W-1:0]            in_addr,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic [A_W-1:0]            w_addr,
  input  logic [N_NEU*DATA_W-1:0]   w_data,
  input  logic [N_NEU*DATA_W-1:0]   b_data,
  output logic [N_NEU*DATA_W-1:0]   out_vec,
  output logic [M_W-1:0]            argmax
);

  if (ACC_W < 2*DATA_W + $clog2(N_IN+1) + 1) begin : g_acc_chk
    $error("ACC_W too narrow: accumulator could wrap over N_IN products");
  end
  if (ACC_W > 64) begin : g_acc_max
    $error("ACC_W above 64 is not supported by the post-processing path");
  end

  state_t                         state, state_nx;
  logic [A_W-1:0]                 k;
  logic                           en;
  logic                           init;
  logic [N_NEU-1:0][DATA_W-1:0]   res;
  logic [M_W-1:0]                 am_nx;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (k == A_W'(N_IN-1)) state_nx = DRAIN;
      DRAIN:   state_nx = ACT;
      ACT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign init    = (state == IDLE) && start;
  assign busy    = (state != IDLE);
  assign in_addr = (state == MAC) ? k : '0;
  assign w_addr  = in_addr;

  // Memory data arrives one cycle after its address, so the lanes accumulate
  // one cycle behind MAC; that lag is what DRAIN covers.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      k       <= '0;
      en      <= 1'b0;
      done    <= 1'b0;
      out_vec <= '0;
      argmax  <= '0;
    end else begin
      k    <= (state == MAC && state_nx == MAC) ? k + A_W'(1) : '0;
      en   <= (state == MAC);
      done <= (state == ACT);
      if (state == ACT) begin
        out_vec <= res;
        argmax  <= am_nx;
      end
    end

  for (genvar n = 0; n < N_NEU; n++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .FRAC   (FRAC),
      .ACC_W  (ACC_W),
      .RELU   (RELU)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .init   (init),
      .en     (en),
      .bias   (b_data[n*DATA_W +: DATA_W]),
      .x      (in_data),
      .w      (w_data[n*DATA_W +: DATA_W]),
      .result (res[n])
    );
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    am_nx = '0;
    for (int n = 1; n < N_NEU; n++)
      if ($signed(res[n]) > $signed(res[am_nx])) am_nx = M_W'(n);
  end

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Bench for mlp_layer_engine: two small instances (linear / ReLU) plus one default instance.
module tb_mlp_layer_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;

  int mx[64];
  int mw[64][10];
  int mb[10];

  logic        start_s, busy_s, done_s, busy_r, done_r;
  logic [1:0]  ia_s, wa_s, ia_r, wa_r;
  logic [7:0]  in_s, in_r;
  logic [15:0] w_s, w_r, b_sm, ov_s, ov_r;
  logic [0:0]  am_s, am_r;

  logic        start_d, busy_d, done_d;
  logic [5:0]  ia_d, wa_d;
  logic [7:0]  in_d;
  logic [79:0] w_d, b_d, ov_d;
  logic [3:0]  am_d;

  mlp_layer_engine #(.DATA_W(8), .FRAC(7), .N_IN(4), .N_NEU(2), .ACC_W(24), .RELU(0)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
    .in_addr(ia_s), .in_data(in_s), .w_addr(wa_s), .w_data(w_s),
    .b_data(b_sm), .out_vec(ov_s), .argmax(am_s));

  mlp_layer_engine #(.DATA_W(8), .FRAC(7), .N_IN(4), .N_NEU(2), .ACC_W(24), .RELU(1)) dut_r (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_r), .done(done_r),
    .in_addr(ia_r), .in_data(in_r), .w_addr(wa_r), .w_data(w_r),
    .b_data(b_sm), .out_vec(ov_r), .argmax(am_r));

  mlp_layer_engine dut_d (
    .clk(clk), .rst(rst), .start(start_d), .busy(busy_d), .done(done_d),
    .in_addr(ia_d), .in_data(in_d), .w_addr(wa_d), .w_data(w_d),
    .b_data(b_d), .out_vec(ov_d), .argmax(am_d));

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    in_s <= 8'(mx[ia_s]);
    in_r <= 8'(mx[ia_r]);
    in_d <= 8'(mx[ia_d]);
    for (int n = 0; n < 2; n++) begin
      w_s[n*8 +: 8] <= 8'(mw[wa_s][n]);
      w_r[n*8 +: 8] <= 8'(mw[wa_r][n]);
    end
    for (int n = 0; n < 10; n++) w_d[n*8 +: 8] <= 8'(mw[wa_d][n]);
  end

  always_comb begin
    b_sm = '0;
    b_d  = '0;
    for (int n = 0; n < 2; n++)  b_sm[n*8 +: 8] = 8'(mb[n]);
    for (int n = 0; n < 10; n++) b_d[n*8 +: 8]  = 8'(mb[n]);
  end

  function automatic int lane(input logic [79:0] v, input int n);
    return int'($signed(v[n*8 +: 8]));
  endfunction

  // Reference: exact integer dot product, floor division by 2^7, clamp, ReLU.
  task automatic ref_layer(input int nin, input int nneu, input bit relu,
                           output int y[10], output int am);
    longint acc, q;
    for (int n = 0; n < 10; n++) y[n] = 0;
    for (int n = 0; n < nneu; n++) begin
      acc = longint'(mb[n]) * 128;
      for (int i = 0; i < nin; i++) acc += longint'(mx[i]) * longint'(mw[i][n]);
      if (acc >= 0) q = acc / 128;
      else          q = -((-acc + 127) / 128);
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      if (relu && q < 0) q = 0;
      y[n] = int'(q);
    end
    am = 0;
    for (int n = 1; n < nneu; n++) if (y[n] > y[am]) am = n;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 64; i++) begin
      mx[i] = int'($urandom_range(0, 255)) - 128;
      for (int n = 0; n < 10; n++) mw[i][n] = int'($urandom_range(0, 255)) - 128;
    end
    for (int n = 0; n < 10; n++) mb[n] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Called at posedge+1; returns the cycle index of done (start cycle = 0).
  task automatic run_small(output int lat, output bit busy_ok);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    lat = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (done_s && done_r) begin
        lat = c;
        if (busy_s || busy_r) busy_ok = 1'b0;
        break;
      end
      if (!(busy_s && busy_r)) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_def(input int poke, output int lat, output int ndone, output bit busy_ok);
    start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    lat = -1;
    ndone = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      start_d = (c == poke);
      if (done_d) begin
        ndone++;
        if (lat < 0) lat = c;
      end
      if (busy_d !== (c <= 64)) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    start_d = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_s = 1'b0; start_d = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mx[i] = 0;
      for (int n = 0; n < 10; n++) mw[i][n] = 0;
    end
    for (int n = 0; n < 10; n++) mb[n] = 0;
    #2 rst = 1'b0;
    #10;
    n_chk++;
    if ({busy_s, done_s, ov_s, am_s, ia_s, wa_s} !== '0)
      $display("FAIL reset_s: got %h want 0", {busy_s, done_s, ov_s, am_s, ia_s, wa_s});
    else n_pass++;
    n_chk++;
    if ({busy_r, done_r, ov_r, am_r, ia_r, wa_r} !== '0)
      $display("FAIL reset_r: got %h want 0", {busy_r, done_r, ov_r, am_r, ia_r, wa_r});
    else n_pass++;
    n_chk++;
    if ({busy_d, done_d, ov_d, am_d, ia_d, wa_d} !== '0)
      $display("FAIL reset_d: got %h want 0", {busy_d, done_d, ov_d, am_d, ia_d, wa_d});
    else n_pass++;
    #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int lat; bit bok;
    for (int i = 0; i < 4; i++) begin mx[i] = 64; mw[i][0] = 64; mw[i][1] = -64; end
    mb[0] = 0; mb[1] = 0;
    run_small(lat, bok);
    n_chk++; if (lat !== 7) $display("FAIL sat_latency: got %0d want 7", lat); else n_pass++;
    n_chk++; if (bok !== 1'b1) $display("FAIL sat_busy: got %0d want 1", bok); else n_pass++;
    n_chk++; if (lane(80'(ov_s), 0) !== 127) $display("FAIL sat_s_lane0: got %0d want 127", lane(80'(ov_s), 0)); else n_pass++;
    n_chk++; if (lane(80'(ov_s), 1) !== -128) $display("FAIL sat_s_lane1: got %0d want -128", lane(80'(ov_s), 1)); else n_pass++;
    n_chk++; if (am_s !== 1'b0) $display("FAIL sat_s_argmax: got %0d want 0", am_s); else n_pass++;
    n_chk++; if (lane(80'(ov_r), 1) !== 0) $display("FAIL sat_r_lane1: got %0d want 0", lane(80'(ov_r), 1)); else n_pass++;
    n_chk++; if (am_r !== 1'b0) $display("FAIL sat_r_argmax: got %0d want 0", am_r); else n_pass++;
  endtask

  task automatic test_neg_relu();
    int lat; bit bok;
    for (int i = 0; i < 4; i++) begin mx[i] = -80; mw[i][0] = 120; mw[i][1] = -120; end
    mb[0] = 0; mb[1] = 0;
    run_small(lat, bok);
    n_chk++; if (lat !== 7) $display("FAIL neg_latency: got %0d want 7", lat); else n_pass++;
    n_chk++; if (lane(80'(ov_s), 0) !== -128) $display("FAIL neg_s_lane0: got %0d want -128", lane(80'(ov_s), 0)); else n_pass++;
    n_chk++; if (lane(80'(ov_r), 0) !== 0) $display("FAIL neg_r_lane0: got %0d want 0", lane(80'(ov_r), 0)); else n_pass++;
    n_chk++; if (lane(80'(ov_r), 1) !== 127) $display("FAIL neg_r_lane1: got %0d want 127", lane(80'(ov_r), 1)); else n_pass++;
    n_chk++; if (am_s !== 1'b1) $display("FAIL neg_s_argmax: got %0d want 1", am_s); else n_pass++;
    n_chk++; if (am_r !== 1'b1) $display("FAIL neg_r_argmax: got %0d want 1", am_r); else n_pass++;
  endtask

  task automatic test_bias();
    int lat, nd; bit bok;
    rand_data();
    for (int i = 0; i < 64; i++) for (int n = 0; n < 10; n++) mw[i][n] = 0;
    for (int n = 0; n < 10; n++) mb[n] = n;
    run_def(0, lat, nd, bok);
    n_chk++; if (lat !== 65) $display("FAIL bias_latency: got %0d want 65", lat); else n_pass++;
    n_chk++; if (nd !== 1) $display("FAIL bias_done_count: got %0d want 1", nd); else n_pass++;
    n_chk++; if (bok !== 1'b1) $display("FAIL bias_busy: got %0d want 1", bok); else n_pass++;
    for (int n = 0; n < 10; n++) begin
      n_chk++;
      if (lane(ov_d, n) !== n) $display("FAIL bias_lane%0d: got %0d want %0d", n, lane(ov_d, n), n);
      else n_pass++;
    end
    n_chk++; if (am_d !== 4'd9) $display("FAIL bias_argmax: got %0d want 9", am_d); else n_pass++;
    for (int n = 0; n < 10; n++) mb[n] = 5;
    run_def(0, lat, nd, bok);
    n_chk++;
    if (ov_d !== {10{8'd5}}) $display("FAIL tie_lanes: got %h want all 05", ov_d); else n_pass++;
    n_chk++; if (am_d !== 4'd0) $display("FAIL tie_argmax: got %0d want 0", am_d); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, nd, am; int y[10]; bit bok;
    rand_data();
    start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    for (int c = 1; c < 20; c++) begin @(posedge clk); #1; end
    n_chk++; if (busy_d !== 1'b1) $display("FAIL rmid_busy_before: got %0d want 1", busy_d); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({busy_d, done_d, ov_d, am_d, ia_d} !== '0)
      $display("FAIL rmid_cleared: got %h want 0", {busy_d, done_d, ov_d, am_d, ia_d});
    else n_pass++;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    ref_layer(62, 10, 1'b1, y, am);
    run_def(0, lat, nd, bok);
    n_chk++; if (lat !== 65) $display("FAIL rmid_latency: got %0d want 65", lat); else n_pass++;
    n_chk++; if (bok !== 1'b1) $display("FAIL rmid_busy: got %0d want 1", bok); else n_pass++;
    for (int n = 0; n < 10; n++) begin
      n_chk++;
      if (lane(ov_d, n) !== y[n]) $display("FAIL rmid_lane%0d: got %0d want %0d", n, lane(ov_d, n), y[n]);
      else n_pass++;
    end
    n_chk++; if (int'(am_d) !== am) $display("FAIL rmid_argmax: got %0d want %0d", am_d, am); else n_pass++;
  endtask

  task automatic test_busy_start();
    int lat, nd, am; int y[10]; bit bok;
    rand_data();
    ref_layer(62, 10, 1'b1, y, am);
    run_def(10, lat, nd, bok);
    n_chk++; if (lat !== 65) $display("FAIL busy_start_latency: got %0d want 65", lat); else n_pass++;
    n_chk++; if (nd !== 1) $display("FAIL busy_start_done_count: got %0d want 1", nd); else n_pass++;
    n_chk++; if (bok !== 1'b1) $display("FAIL busy_start_busy: got %0d want 1", bok); else n_pass++;
    for (int n = 0; n < 10; n++) begin
      n_chk++;
      if (lane(ov_d, n) !== y[n]) $display("FAIL busy_start_lane%0d: got %0d want %0d", n, lane(ov_d, n), y[n]);
      else n_pass++;
    end
    n_chk++; if (int'(am_d) !== am) $display("FAIL busy_start_argmax: got %0d want %0d", am_d, am); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ys[10], yr[10];
    int ams, amr, c;
    rand_data();
    ref_layer(4, 2, 1'b0, ys, ams);
    ref_layer(4, 2, 1'b1, yr, amr);
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int v = 0; v < 1000; v++) begin
      c = 1;
      while (!(done_s && done_r) && c < 20) begin @(posedge clk); #1; c++; end
      n_chk++;
      if (c !== 7) $display("FAIL b2b_latency v%0d: got %0d want 7", v, c); else n_pass++;
      n_chk++;
      if (lane(80'(ov_s), 0) !== ys[0] || lane(80'(ov_s), 1) !== ys[1] || int'(am_s) !== ams)
        $display("FAIL b2b_s v%0d: got %0d %0d am %0d want %0d %0d am %0d", v,
                 lane(80'(ov_s), 0), lane(80'(ov_s), 1), am_s, ys[0], ys[1], ams);
      else n_pass++;
      n_chk++;
      if (lane(80'(ov_r), 0) !== yr[0] || lane(80'(ov_r), 1) !== yr[1] || int'(am_r) !== amr)
        $display("FAIL b2b_r v%0d: got %0d %0d am %0d want %0d %0d am %0d", v,
                 lane(80'(ov_r), 0), lane(80'(ov_r), 1), am_r, yr[0], yr[1], amr);
      else n_pass++;
      if (v < 999) begin
        rand_data();
        ref_layer(4, 2, 1'b0, ys, ams);
        ref_layer(4, 2, 1'b1, yr, amr);
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_neg_relu();
    test_bias();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
